// File: rtl/audio_envelope_pwm.sv
// -----------------------------------------------------------------------------
// audio_envelope_pwm
//
// Output stage behind the song/effect player. Shapes the player's 1-bit
// square-wave tone with an attack/sustain/release envelope, scales it by a
// 4-bit volume, and drives the mono amplifier through an 8-bit PWM pin plus
// its shutdown pin. Removes clicks at note-sequence start and stop.
//
// Ports:
//   clock     in   system clock, all logic on the rising edge
//   reset     in   asynchronous, active-high
//   toneIn    in   square-wave tone from the player, synchronous to clock
//   volume    in   [3:0] linear gain 0..15, 0 = silent
//   audioPwm  out  registered PWM audio to the amplifier (256-clock period)
//   aud_sd    out  amplifier enable (1 = on)
//   envLevel  out  [7:0] current envelope level
//   busy      out  high whenever the envelope is not IDLE
//
// Build option:
//   AUDIO_SOFT_SHUTDOWN_EN  when defined, aud_sd is a register that switches
//                           the amplifier on when a note sequence starts and
//                           off again once the release has reached zero.
//                           When undefined, aud_sd is tied high.
//
// Envelope states:
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | level 0, waiting for the first tone edge
//   ATTACK  | level rises by 1 every ATTACK_STEP_CYCLES clocks
//   SUSTAIN | level held at 255 while the tone keeps toggling
//   RELEASE | level falls by 1 every RELEASE_STEP_CYCLES clocks
// -----------------------------------------------------------------------------
module audio_envelope_pwm #(
    parameter int CLOCK_FREQUENCY     = 50_000_000,
    parameter int ATTACK_STEP_CYCLES  = 5_000,
    parameter int RELEASE_STEP_CYCLES = 20_000,
    parameter int SILENCE_CYCLES      = 500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       toneIn,
    input  logic [3:0] volume,
    output logic       audioPwm,
    output logic       aud_sd,
    output logic [7:0] envLevel,
    output logic       busy
);

    localparam int STEP_MAX = (ATTACK_STEP_CYCLES > RELEASE_STEP_CYCLES) ?
                              ATTACK_STEP_CYCLES : RELEASE_STEP_CYCLES;
    localparam int STEP_W   = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;
    localparam int SIL_W    = $clog2(SILENCE_CYCLES + 1);

    localparam logic [STEP_W-1:0] ATTACK_TC   = STEP_W'(ATTACK_STEP_CYCLES - 1);
    localparam logic [STEP_W-1:0] RELEASE_TC  = STEP_W'(RELEASE_STEP_CYCLES - 1);
    localparam logic [SIL_W-1:0]  SILENCE_MAX = SIL_W'(SILENCE_CYCLES);
    localparam logic [7:0]        DUTY_MID    = 8'd128;

    if (CLOCK_FREQUENCY < 1 || ATTACK_STEP_CYCLES < 1 ||
        RELEASE_STEP_CYCLES < 1 || SILENCE_CYCLES < 1) begin : g_bad_param
        $error("audio_envelope_pwm: clock and cycle parameters must be positive");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        level_q, level_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [SIL_W-1:0]  silent_cnt_q;
    logic              tone_q;
    logic              tone_edge;
    logic              active;
    logic [7:0]        pwm_cnt_q;
    logic [7:0]        duty_q;
    logic [11:0]       product;
    logic [7:0]        amp;
    logic [6:0]        half;
    logic [7:0]        sample_duty;

    // ---------------------------------------------------------------------
    // Tone edge detect and silence timer
    // ---------------------------------------------------------------------
    assign tone_edge = toneIn ^ tone_q;
    assign active    = (silent_cnt_q < SILENCE_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tone_q <= 1'b0;
        end else begin
            tone_q <= toneIn;
        end
    end

    // Starts saturated so the block comes out of reset treating the input
    // as silent; only a real tone edge makes it active.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            silent_cnt_q <= SILENCE_MAX;
        end else if (tone_edge) begin
            silent_cnt_q <= '0;
        end else if (silent_cnt_q != SILENCE_MAX) begin
            silent_cnt_q <= silent_cnt_q + SIL_W'(1);
        end
    end

    // ---------------------------------------------------------------------
    // Envelope FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            level_q    <= 8'd0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    // step_cnt_d defaults to 0, so a terminal count, any state change and
    // the IDLE/SUSTAIN states all leave the step counter cleared.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        step_cnt_d = '0;
        unique case (state_q)
            IDLE: begin
                level_d = 8'd0;
                if (tone_edge) begin
                    state_d = ATTACK;
                end
            end
            ATTACK: begin
                if (!active) begin
                    state_d = RELEASE;
                end else if (level_q == 8'd255) begin
                    // retrigger from a release that had not yet stepped down
                    state_d = SUSTAIN;
                end else if (step_cnt_q == ATTACK_TC) begin
                    level_d = level_q + 8'd1;
                    if (level_q == 8'd254) begin
                        state_d = SUSTAIN;
                    end
                end else begin
                    step_cnt_d = step_cnt_q + STEP_W'(1);
                end
            end
            SUSTAIN: begin
                level_d = 8'd255;
                if (!active) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // A new edge beats a coincident step: resume the attack from
                // the current level without taking this decrement.
                if (tone_edge) begin
                    state_d = ATTACK;
                end else if (level_q == 8'd0) begin
                    state_d = IDLE;
                end else if (step_cnt_q == RELEASE_TC) begin
                    level_d = level_q - 8'd1;
                    if (level_q == 8'd1) begin
                        state_d = IDLE;
                    end
                end else begin
                    step_cnt_d = step_cnt_q + STEP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                level_d = 8'd0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Amplitude and sample duty
    // ---------------------------------------------------------------------
    // 255 * 15 = 3825 fits in 12 bits; amp tops out at 239 and half at 119,
    // so 128 +/- half stays within 9..247 without wrapping.
    assign product = {4'd0, level_q} * {8'd0, volume};
    assign amp     = 8'(product >> 4);
    assign half    = 7'(amp >> 1);

    always_comb begin
        sample_duty = DUTY_MID;
        if (state_q != IDLE) begin
            sample_duty = tone_q ? (DUTY_MID + {1'b0, half})
                                 : (DUTY_MID - {1'b0, half});
        end
    end

    // ---------------------------------------------------------------------
    // PWM: duty only reloads on the last count of a period, so envelope and
    // volume changes never cut a period short.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_cnt_q <= 8'd0;
            duty_q    <= DUTY_MID;
            audioPwm  <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            if (pwm_cnt_q == 8'd255) begin
                duty_q <= sample_duty;
            end
            audioPwm <= (pwm_cnt_q < duty_q);
        end
    end

    // ---------------------------------------------------------------------
    // Amplifier shutdown
    // ---------------------------------------------------------------------
`ifdef AUDIO_SOFT_SHUTDOWN_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aud_sd <= 1'b0;
        end else if (state_q == IDLE && state_d == ATTACK) begin
            aud_sd <= 1'b1;
        end else if (state_q != IDLE && state_d == IDLE) begin
            aud_sd <= 1'b0;
        end
    end
`else
    assign aud_sd = 1'b1;
`endif

    assign envLevel = level_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_audio_envelope_pwm.sv
module tb_audio_envelope_pwm;

    localparam int A_STEP = 4;
    localparam int R_STEP = 8;
    localparam int SIL    = 64;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ATTACK  = 2'd1;
    localparam logic [1:0] S_SUSTAIN = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

`ifdef AUDIO_SOFT_SHUTDOWN_EN
    localparam logic SD_OFF = 1'b0;
`else
    localparam logic SD_OFF = 1'b1;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       toneIn;
    logic [3:0] volume;
    logic       audioPwm;
    logic       aud_sd;
    logic [7:0] envLevel;
    logic       busy;

    int tests = 0;
    int fails = 0;
    bit tone_en = 1'b0;
    int tone_div = 0;

    always #5 clock = ~clock;

    audio_envelope_pwm #(
        .CLOCK_FREQUENCY    (50_000_000),
        .ATTACK_STEP_CYCLES (A_STEP),
        .RELEASE_STEP_CYCLES(R_STEP),
        .SILENCE_CYCLES     (SIL)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .toneIn  (toneIn),
        .volume  (volume),
        .audioPwm(audioPwm),
        .aud_sd  (aud_sd),
        .envLevel(envLevel),
        .busy    (busy)
    );

    logic [1:0] st;
    assign st = dut.state_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // One clock per iteration; outputs are sampled 1 time unit after the
    // rising edge, and the tone (when enabled) toggles every 10 clocks.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (tone_en) begin
                tone_div++;
                if (tone_div == 10) begin
                    tone_div = 0;
                    toneIn = ~toneIn;
                end
            end
        end
    endtask

    task automatic wait_level(input string tag, input logic [7:0] tgt, input int bound);
        for (int i = 0; i < bound && envLevel !== tgt; i++) tick(1);
        check(tag, envLevel, tgt);
    endtask

    task automatic wait_state(input string tag, input logic [1:0] tgt, input int bound);
        for (int i = 0; i < bound && st !== tgt; i++) tick(1);
        check(tag, st, tgt);
    endtask

    // Aligns to pwmCnt == 0 and counts high samples over one full period.
    task automatic measure(output int hi);
        for (int i = 0; i < 300 && dut.pwm_cnt_q !== 8'd0; i++) tick(1);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            tick(1);
            if (audioPwm === 1'b1) hi++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int  hi;
        int  n;
        bit  saw_hi;
        bit  saw_lo;

        reset  = 1'b1;
        toneIn = 1'b0;
        volume = 4'd15;
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_env", envLevel, 0);
        check("rst_pwm", audioPwm, 0);
        check("rst_duty", dut.duty_q, 128);
        check("rst_state", st, S_IDLE);
        check("rst_sd", aud_sd, SD_OFF);
        reset = 1'b0;
        tick(2);
        check("idle_no_edge", st, S_IDLE);

        // full attack
        toneIn = 1'b1; tone_en = 1'b1; tone_div = 0;
        tick(1);
        check("atk_entry_state", st, S_ATTACK);
        check("atk_entry_busy", busy, 1);
        check("atk_entry_env", envLevel, 0);
        check("atk_entry_sd", aud_sd, 1);
        tick(4);
        check("atk_step1", envLevel, 1);
        tick(1015);
        check("atk_1019_env", envLevel, 254);
        check("atk_1019_state", st, S_ATTACK);
        tick(1);
        check("atk_1020_env", envLevel, 255);
        check("atk_1020_state", st, S_SUSTAIN);

        // full-scale PWM: 128 +/- 119
        saw_hi = 1'b0; saw_lo = 1'b0;
        for (int p = 0; p < 5; p++) begin
            measure(hi);
            check("pwm_full_count", (hi == 247 || hi == 9), 1);
            if (hi == 247) saw_hi = 1'b1;
            if (hi == 9) saw_lo = 1'b1;
        end
        check("pwm_full_both_phases", {saw_hi, saw_lo}, 2'b11);

        // volume 0
        volume = 4'd0;
        tick(1);
        measure(hi);
        check("pwm_vol0_a", hi, 128);
        measure(hi);
        check("pwm_vol0_b", hi, 128);

        // volume 15 -> 8 mid-period
        volume = 4'd15;
        tick(1);
        for (int i = 0; i < 300 && dut.pwm_cnt_q !== 8'd0; i++) tick(1);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            tick(1);
            if (audioPwm === 1'b1) hi++;
            if (dut.pwm_cnt_q == 8'd100) volume = 4'd8;
        end
        check("vol_change_cur_period", (hi == 247 || hi == 9), 1);
        measure(hi);
        check("vol_change_next_period", (hi == 191 || hi == 65), 1);
        measure(hi);
        check("vol_change_later_period", (hi == 191 || hi == 65), 1);
        volume = 4'd15;

        // release to idle
        tone_en = 1'b0;
        tick(2);
        toneIn = ~toneIn;
        tick(1);
        n = 0;
        while (st !== S_RELEASE && n < 100) begin
            tick(1);
            n++;
        end
        check("rel_silence_delay", (n >= 64 && n <= 65), 1);
        check("rel_entry_env", envLevel, 255);
        tick(8);
        check("rel_step1", envLevel, 254);
        tick(2031);
        check("rel_2039_env", envLevel, 1);
        check("rel_2039_state", st, S_RELEASE);
        check("rel_2039_sd", aud_sd, 1);
        tick(1);
        check("rel_2040_env", envLevel, 0);
        check("rel_2040_state", st, S_IDLE);
        check("rel_2040_busy", busy, 0);
        check("rel_2040_sd", aud_sd, SD_OFF);

        // async reset mid-attack at 37
        toneIn = ~toneIn; tone_en = 1'b1; tone_div = 0;
        tick(1);
        check("atk2_entry_state", st, S_ATTACK);
        wait_level("atk2_reach_37", 8'd37, 300);
        check("atk2_37_state", st, S_ATTACK);
        #2;
        reset = 1'b1;
        #1;
        check("arst_state", st, S_IDLE);
        check("arst_env", envLevel, 0);
        check("arst_busy", busy, 0);
        check("arst_pwm", audioPwm, 0);
        check("arst_duty", dut.duty_q, 128);
        check("arst_sd", aud_sd, SD_OFF);
        tone_en = 1'b0;
        toneIn = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(2);
        check("post_rst_idle", st, S_IDLE);
        toneIn = 1'b1; tone_en = 1'b1; tone_div = 0;
        tick(1);
        check("post_rst_atk", st, S_ATTACK);
        check("post_rst_env0", envLevel, 0);
        tick(4);
        check("post_rst_env1", envLevel, 1);
        wait_state("atk3_sustain", S_SUSTAIN, 1100);

        // retrigger from release at 100
        tone_en = 1'b0;
        tick(2);
        toneIn = ~toneIn;
        tick(1);
        wait_level("rel2_reach_100", 8'd100, 2000);
        check("rel2_100_state", st, S_RELEASE);
        toneIn = ~toneIn; tone_en = 1'b1; tone_div = 0;
        tick(1);
        check("retrig_state", st, S_ATTACK);
        check("retrig_env", envLevel, 100);
        tick(4);
        check("retrig_101", envLevel, 101);
        tick(4);
        check("retrig_102", envLevel, 102);
        tick(4);
        check("retrig_103", envLevel, 103);
        wait_state("retrig_sustain", S_SUSTAIN, 800);

        // edge coincident with a release step terminal
        tone_en = 1'b0;
        tick(2);
        toneIn = ~toneIn;
        tick(1);
        wait_level("rel3_reach_60", 8'd60, 3000);
        tick(7);
        check("coinc_pre_env", envLevel, 60);
        toneIn = ~toneIn;
        tick(1);
        check("coinc_state", st, S_ATTACK);
        check("coinc_env", envLevel, 60);
        tone_en = 1'b1; tone_div = 0;
        tick(4);
        check("coinc_next_step", envLevel, 61);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/audio_envelope_pwm.md
# audio_envelope_pwm

Output stage directly downstream of the song/effect player. Takes the player's 1-bit square-wave tone, shapes it with an attack/sustain/release amplitude envelope scaled by a 4-bit volume, and drives the board's mono audio amplifier through an 8-bit PWM pin plus its shutdown pin. It removes the clicks at note-sequence start and stop and gives software-free volume control.

## Interface
- CLOCK_FREQUENCY, 50_000_000, system clock in Hz (documentation/derivation only)
- ATTACK_STEP_CYCLES, 5_000, clocks per +1 envelope step in ATTACK (255 steps, about 25.5 ms)
- RELEASE_STEP_CYCLES, 20_000, clocks per -1 envelope step in RELEASE (about 102 ms)
- SILENCE_CYCLES, 500_000, clocks without a toneIn edge before input counts as silent (10 ms)

- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- toneIn  in  1  square-wave tone from player, synchronous to clock
- volume  in  4  linear gain 0..15, 0 = silent
- audioPwm  out  1  PWM audio to amplifier
- aud_sd  out  1  amplifier enable (1 = on)
- envLevel  out  8  current envelope level
- busy  out  1  high whenever state is not IDLE

## Operation
- Edge detect: toneQ <= toneIn; edge = toneIn ^ toneQ.
- Silence counter: reset to SILENCE_CYCLES. Cleared to 0 on edge, otherwise increments and saturates at SILENCE_CYCLES. active = (silentCnt < SILENCE_CYCLES).
- States: IDLE, ATTACK, SUSTAIN, RELEASE.
  - IDLE: level 0. On edge, go to ATTACK.
  - ATTACK: stepCnt counts 0..ATTACK_STEP_CYCLES-1. At the terminal count, level += 1. When the increment reaches 255, go to SUSTAIN. If !active, go to RELEASE with level unchanged.
  - SUSTAIN: level holds at 255. If !active, go to RELEASE.
  - RELEASE: same stepping with RELEASE_STEP_CYCLES, level -= 1. Level reaching 0 goes to IDLE. An edge goes to ATTACK from the current level (no drop).
  - stepCnt clears to 0 on every state change and is held at 0 in IDLE and SUSTAIN.
  - Simultaneous edge and step terminal in RELEASE: ATTACK wins and this step's decrement is discarded.
- Amplitude: amp = (level × volume) >> 4. The product is 12-bit and amp is 8-bit, maximum 239. half = amp >> 1.
- Sample duty: toneQ ? 128 + half : 128 - half. Range 9..247, no overflow possible. IDLE gives 128.
- PWM: free-running 8-bit pwmCnt wraps 255 to 0.
  - dutyReg loads the sample duty only on the cycle pwmCnt == 255, so a new value takes effect from the next period. This keeps volume and envelope changes glitch-free.
  - audioPwm <= (pwmCnt < dutyReg), registered.
- envLevel = level. busy = (state != IDLE).

## Timing
- Reset values:
  - state IDLE, level 0, stepCnt 0, pwmCnt 0, dutyReg 128, toneQ 0
  - silentCnt SILENCE_CYCLES
  - audioPwm 0, envLevel 0, busy 0
  - aud_sd per Configuration
- The edge is seen at the clock edge where toneIn differs from toneQ; state is ATTACK and busy is 1 after that same edge.
- Attack from 0 to 255 takes exactly 255 × ATTACK_STEP_CYCLES clocks after entering ATTACK. Release from 255 to 0 takes 255 × RELEASE_STEP_CYCLES clocks.
- Silence is detected SILENCE_CYCLES clocks after the last edge, when silentCnt reaches saturation.
- Duty-to-pin latency: at most 256 clocks to the next wrap, plus 1 registered cycle.
- The PWM period is always 256 clocks (195.3 kHz at 50 MHz). Duty is never updated mid-period.
- Reset asserted mid-operation forces all reset values immediately. After release, the block restarts from IDLE.

## Configuration
- AUDIO_SOFT_SHUTDOWN_EN defined:
  - aud_sd is a register, 0 at reset.
  - aud_sd goes to 1 on the clock entering ATTACK from IDLE.
  - aud_sd goes to 0 on the clock entering IDLE.
  - The amplifier is off while silent.
- Undefined: aud_sd is tied to constant 1, and reset has no effect on it.

## Test plan
Bench parameters: ATTACK_STEP_CYCLES=4, RELEASE_STEP_CYCLES=8, SILENCE_CYCLES=64.
- Reset:
  - assert reset mid-cycle with toneIn toggling -> audioPwm=0, busy=0, envLevel=0, dutyReg=128 immediately
  - aud_sd=0 with the macro, 1 without
- Full attack:
  - toneIn toggling every 10 clocks, volume=15 -> ATTACK at the first edge; envLevel=255 and SUSTAIN exactly 1020 clocks later
  - PWM high count per period is 247 (tone high) or 9 (tone low)
- Release:
  - stop toggling in SUSTAIN -> RELEASE 64 clocks after the last edge
  - IDLE, envLevel=0 and busy=0 exactly 2040 clocks later
  - with the macro, aud_sd falls on the IDLE entry clock
- Retrigger:
  - restart toggling when envLevel=100 in RELEASE -> ATTACK, envLevel continues 100,101,…, never drops below 100
  - an edge coincident with a release step terminal leaves envLevel unchanged
- Volume:
  - volume=0 in SUSTAIN -> every PWM period has 128 high clocks
  - volume changed 15 to 8 at pwmCnt=100 -> current period unchanged; the next period uses amp=127, half=63, duty 191/65
- Async reset mid-attack at envLevel=37 -> state IDLE and envLevel=0 without waiting for a clock edge; normal attack resumes after the next edge post-reset.
